// File: rtl/mux3_pkg.sv
// mux3_pkg: shared select-index encoding for the mux3 data selector.
//   sel_idx_t - 2-bit index of the selected data input (0, 1 or 2; never 3)
//   SEL_D0/1/2 - index values for D0, D1 and D2
package mux3_pkg;

    typedef logic [1:0] sel_idx_t;

    localparam sel_idx_t SEL_D0 = 2'd0;
    localparam sel_idx_t SEL_D1 = 2'd1;
    localparam sel_idx_t SEL_D2 = 2'd2;

endpackage

// File: rtl/mux3_sel_decode.sv
// mux3_sel_decode: maps the two select pins to a data-input index.
// This is the only place the select priority is expressed (S1 over S0), so the
// combinational data path and the registered index always agree.
// Ports:
//   s1_i       - select MSB
//   s0_i       - select LSB
//   sel_o      - decoded index (SEL_D0/SEL_D1/SEL_D2)
//   is_alias_o - high for the aliased code {S1,S0}=11 (which also selects D2)
module mux3_sel_decode
    import mux3_pkg::*;
(
    input  logic     s1_i,
    input  logic     s0_i,
    output sel_idx_t sel_o,
    output logic     is_alias_o
);

    // Conditional operators (rather than case/if) let an X on a select pin
    // propagate into the index instead of silently picking a branch.
    always_comb begin
        sel_o      = s1_i ? SEL_D2 : (s0_i ? SEL_D1 : SEL_D0);
        is_alias_o = s1_i & s0_i;
    end

endmodule

// File: rtl/mux3.sv
// mux3: parameterised 3:1 data selector with a registered copy of the output.
// Ports:
//   clk        - clock, rising-edge active
//   rst_n      - asynchronous active-low reset (clears registered state only)
//   D0, D1, D2 - W-bit data inputs
//   S1, S0     - select ({S1,S0}: 00->D0, 01->D1, 10->D2, 11->D2 aliased)
//   Out        - combinational selected data, not gated by reset
//   Out_r      - Out registered on clk
//   sel_r      - registered index of the selected input (0, 1 or 2)
//   alias_seen - sticky flag, set when {S1,S0}=11 is sampled; cleared by reset only
module mux3
    import mux3_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] D0,
    input  logic [W-1:0] D1,
    input  logic [W-1:0] D2,
    input  logic         S0,
    input  logic         S1,
    output logic [W-1:0] Out,
    output logic [W-1:0] Out_r,
    output logic [1:0]   sel_r,
    output logic         alias_seen
);

    sel_idx_t     sel_idx;
    logic         is_alias;

    logic [W-1:0] out_r_q;
    sel_idx_t     sel_r_q;
    logic         alias_q;
    logic         alias_d;

    mux3_sel_decode u_sel_decode (
        .s1_i       (S1),
        .s0_i       (S0),
        .sel_o      (sel_idx),
        .is_alias_o (is_alias)
    );

    // Data selection keys off the decoded index only, never the raw pins.
    always_comb begin
        Out = (sel_idx == SEL_D2) ? D2 : ((sel_idx == SEL_D1) ? D1 : D0);
    end

    always_comb begin
        alias_d = alias_q | is_alias;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r_q <= '0;
            sel_r_q <= SEL_D0;
            alias_q <= 1'b0;
        end else begin
            out_r_q <= Out;
            sel_r_q <= sel_idx;
            alias_q <= alias_d;
        end
    end

    assign Out_r      = out_r_q;
    assign sel_r      = sel_r_q;
    assign alias_seen = alias_q;

endmodule

// File: tb/tb_mux3.sv
// tb_mux3: self-checking bench for mux3 with a W=5 and a W=1 instance.
module tb_mux3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] d0, d1, d2;
    logic       s0, s1;
    logic [4:0] out5, out_r5;
    logic [1:0] sel_r5;
    logic       alias5;

    logic       b0, b1, b2;
    logic       out1, out_r1;
    logic [1:0] sel_r1;
    logic       alias1;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0] out;
        logic [1:0] sel;
    } exp_t;

    exp_t sb_q[$];

    always #20 clk = ~clk;

    mux3 #(.W(5)) u_dut5 (
        .clk        (clk),
        .rst_n      (rst_n),
        .D0         (d0),
        .D1         (d1),
        .D2         (d2),
        .S0         (s0),
        .S1         (s1),
        .Out        (out5),
        .Out_r      (out_r5),
        .sel_r      (sel_r5),
        .alias_seen (alias5)
    );

    mux3 #(.W(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .D0         (b0),
        .D1         (b1),
        .D2         (b2),
        .S0         (s0),
        .S1         (s1),
        .Out        (out1),
        .Out_r      (out_r1),
        .sel_r      (sel_r1),
        .alias_seen (alias1)
    );

    // Golden model of the selector, written from the select truth table.
    function automatic logic [4:0] gold_out(input logic [4:0] a, input logic [4:0] b,
                                            input logic [4:0] c, input logic hi,
                                            input logic lo);
        if (hi) return c;
        else if (lo) return b;
        else return a;
    endfunction

    function automatic logic [1:0] gold_idx(input logic hi, input logic lo);
        if (hi) return 2'd2;
        else if (lo) return 2'd1;
        else return 2'd0;
    endfunction

    // Expected registered values for the current inputs, consumed after the next edge.
    task automatic sb_push();
        exp_t e;
        e.out = gold_out(d0, d1, d2, s1, s0);
        e.sel = gold_idx(s1, s0);
        sb_q.push_back(e);
    endtask

    task automatic sb_pop(output exp_t e, output bit ok);
        ok = (sb_q.size() != 0);
        if (ok) e = sb_q.pop_front();
        else e = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        d0 = 5'h00; d1 = 5'h00; d2 = 5'h00; s0 = 1'b0; s1 = 1'b0;
        b0 = 1'b0; b1 = 1'b0; b2 = 1'b0;
        #2 rst_n = 1'b0;
        #2;
        total++;
        if (out_r5 !== 5'h00) begin
            bad++; $display("FAIL reset_out_r actual=%h required=00", out_r5);
        end
        total++;
        if (sel_r5 !== 2'd0) begin
            bad++; $display("FAIL reset_sel_r actual=%0d required=0", sel_r5);
        end
        total++;
        if (alias5 !== 1'b0) begin
            bad++; $display("FAIL reset_alias actual=%b required=0", alias5);
        end
    endtask

    task automatic test_sweep();
        logic [4:0] exp_out[4] = '{5'h03, 5'h11, 5'h1C, 5'h1C};
        logic [1:0] exp_sel[4] = '{2'd0, 2'd1, 2'd2, 2'd2};
        exp_t e;
        bit ok;
        @(negedge clk);
        rst_n = 1'b1;
        d0 = 5'h03; d1 = 5'h11; d2 = 5'h1C;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            s1 = i[1]; s0 = i[0];
            #10;
            total++;
            if (out5 !== exp_out[i]) begin
                bad++; $display("FAIL sweep_out code=%0d actual=%h required=%h", i, out5, exp_out[i]);
            end
            sb_push();
            @(posedge clk); #1;
            sb_pop(e, ok);
            total++;
            if (!ok) begin
                bad++; $display("FAIL sweep_sb_empty code=%0d", i);
            end else if (out_r5 !== e.out || sel_r5 !== e.sel) begin
                bad++; $display("FAIL sweep_reg code=%0d actual=%h/%0d required=%h/%0d",
                                i, out_r5, sel_r5, e.out, e.sel);
            end
            total++;
            if (sel_r5 !== exp_sel[i]) begin
                bad++; $display("FAIL sweep_sel_r code=%0d actual=%0d required=%0d", i, sel_r5, exp_sel[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] want;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            d0 = 5'($urandom); d1 = 5'($urandom); d2 = 5'($urandom);
            s0 = 1'($urandom); s1 = 1'($urandom);
            #10;
            want = gold_out(d0, d1, d2, s1, s0);
            total++;
            if (out5 !== want) begin
                bad++; $display("FAIL random_out iter=%0d actual=%h required=%h", i, out5, want);
                break;
            end
        end
    endtask

    task automatic test_registered();
        exp_t e;
        bit ok;
        @(negedge clk);
        d0 = 5'h0A; d1 = 5'h15; d2 = 5'h07; s1 = 1'b0; s0 = 1'b1;
        sb_push();
        @(posedge clk); #1;
        sb_pop(e, ok);
        total++;
        if (!ok || out_r5 !== e.out || sel_r5 !== e.sel) begin
            bad++; $display("FAIL reg_first actual=%h/%0d required=%h/%0d", out_r5, sel_r5, e.out, e.sel);
        end
        // Mid-cycle change: outputs must hold until the next rising edge.
        #9;
        s1 = 1'b1; s0 = 1'b0;
        #1;
        total++;
        if (out5 !== 5'h07) begin
            bad++; $display("FAIL reg_comb_track actual=%h required=07", out5);
        end
        total++;
        if (out_r5 !== e.out || sel_r5 !== e.sel) begin
            bad++; $display("FAIL reg_hold actual=%h/%0d required=%h/%0d", out_r5, sel_r5, e.out, e.sel);
        end
        sb_push();
        @(posedge clk); #1;
        sb_pop(e, ok);
        total++;
        if (!ok || out_r5 !== e.out || sel_r5 !== e.sel) begin
            bad++; $display("FAIL reg_second actual=%h/%0d required=%h/%0d", out_r5, sel_r5, e.out, e.sel);
        end
    endtask

    task automatic test_alias();
        @(negedge clk);
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        d0 = 5'h01; d1 = 5'h11; d2 = 5'h02; s1 = 1'b0; s0 = 1'b0;
        @(posedge clk); #1;
        total++;
        if (alias5 !== 1'b0) begin
            bad++; $display("FAIL alias_pre actual=%b required=0", alias5);
        end
        @(negedge clk);
        s1 = 1'b1; s0 = 1'b1;
        @(posedge clk); #1;
        total++;
        if (alias5 !== 1'b1) begin
            bad++; $display("FAIL alias_set actual=%b required=1", alias5);
        end
        @(negedge clk);
        s1 = 1'b0; s0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            total++;
            if (alias5 !== 1'b1) begin
                bad++; $display("FAIL alias_sticky edge=%0d actual=%b required=1", i, alias5);
            end
        end
        // Reset pulse between edges clears everything without a clock.
        #5 rst_n = 1'b0;
        #1;
        total++;
        if (alias5 !== 1'b0 || out_r5 !== 5'h00 || sel_r5 !== 2'd0) begin
            bad++; $display("FAIL alias_reset_pulse actual=%b/%h/%0d required=0/00/0",
                            alias5, out_r5, sel_r5);
        end
        // Aliased code present on the first edge after reset release is captured.
        @(negedge clk);
        s1 = 1'b1; s0 = 1'b1;
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (alias5 !== 1'b1 || sel_r5 !== 2'd2 || out_r5 !== 5'h02) begin
            bad++; $display("FAIL alias_release_edge actual=%b/%0d/%h required=1/2/02",
                            alias5, sel_r5, out_r5);
        end
    endtask

    task automatic test_reset_indep();
        logic [4:0] want;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            d0 = 5'($urandom); d1 = 5'($urandom); d2 = 5'($urandom);
            s1 = i[1]; s0 = i[0];
            #10;
            want = gold_out(d0, d1, d2, s1, s0);
            total++;
            if (out5 !== want) begin
                bad++; $display("FAIL rst_comb code=%0d actual=%h required=%h", i, out5, want);
            end
            @(posedge clk); #1;
            total++;
            if (out_r5 !== 5'h00 || sel_r5 !== 2'd0 || alias5 !== 1'b0) begin
                bad++; $display("FAIL rst_hold code=%0d actual=%h/%0d/%b required=00/0/0",
                                i, out_r5, sel_r5, alias5);
            end
        end
    endtask

    task automatic test_w1();
        logic exp_o[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [1:0] exp_s[4] = '{2'd0, 2'd1, 2'd2, 2'd2};
        @(negedge clk);
        rst_n = 1'b1;
        b0 = 1'b0; b1 = 1'b1; b2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i != 0) @(negedge clk);
            s1 = i[1]; s0 = i[0];
            #10;
            total++;
            if (out1 !== exp_o[i]) begin
                bad++; $display("FAIL w1_out code=%0d actual=%b required=%b", i, out1, exp_o[i]);
            end
            @(posedge clk); #1;
            total++;
            if (sel_r1 !== exp_s[i] || out_r1 !== exp_o[i]) begin
                bad++; $display("FAIL w1_reg code=%0d actual=%0d/%b required=%0d/%b",
                                i, sel_r1, out_r1, exp_s[i], exp_o[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep();
        test_random();
        test_registered();
        test_alias();
        test_reset_indep();
        test_w1();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
